// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the data-memory responder
package dmem_responder_pkg;

    // Number of byte lanes in one RAM word
    localparam int DMEM_LANES = 4;

    // Request as produced by the execute stage: ex_out, rf_rdata2, dmem_wr_en
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } dmem_req_t;

    // Response returned to the memory stage
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between pipeline and responder
interface dmem_responder_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Pipeline side: issues requests, consumes responses and the stall
    modport master (
        output req_valid, req_addr, req_wdata, req_we,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, req_wdata, req_we,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte-lane writes and registered read
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // A strobe-free access is a read; otherwise only the enabled lanes are written
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end else begin
                for (int i = 0; i < DMEM_LANES; i++) begin
                    if (we_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-stage responder with programmable wait states
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dmem_req_t     req_q, req_live, cmd;
    dmem_resp_t    resp;

    logic          req_ready;
    logic          accept;
    logic          latch;
    logic          enter_resp;
    logic [31:0]   cmd_word;
    logic          cmd_in_range;
    logic          cmd_is_load;
    logic          resp_err_q;
    logic          resp_load_q;
    logic          ram_en;
    logic [31:0]   ram_rdata;
    logic          unused_addr_bits;

    assign req_ready = (state_q != WAIT);
    assign accept    = bus.req_valid & req_ready;
    assign req_live  = {bus.req_addr, bus.req_wdata, bus.req_we};

    // With no wait states the commit happens on the accept edge itself, so the
    // live request drives the RAM; otherwise the latched copy does.
    assign cmd          = accept ? req_live : req_q;
    assign cmd_word     = {2'b00, cmd.addr[31:2]};
    assign cmd_in_range = (cmd_word < 32'(DEPTH));
    assign cmd_is_load  = (cmd.we == 4'b0000);
    assign unused_addr_bits = ^cmd.addr[1:0];

    // Next-state logic: accept from IDLE/RESP, count down in WAIT, commit on entry to RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch and response qualifiers; qualifiers are only set on entry to RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            resp_err_q  <= 1'b0;
            resp_load_q <= 1'b0;
        end else begin
            if (latch) begin
                req_q <= req_live;
            end
            resp_err_q  <= enter_resp & ~cmd_in_range;
            resp_load_q <= enter_resp & cmd_in_range & cmd_is_load;
        end
    end

    // Out-of-range requests never touch the RAM; reset blocks any stray commit
    assign ram_en = enter_resp & cmd_in_range & rst_n;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (cmd.we),
        .addr_i  (cmd.addr[AW+1:2]),
        .wdata_i (cmd.wdata),
        .rdata_o (ram_rdata)
    );

    assign resp.valid = (state_q == RESP);
    assign resp.rdata = (resp.valid & resp_load_q) ? ram_rdata : 32'h0;
    assign resp.err   = resp_err_q;

    assign bus.req_ready  = req_ready;
    assign bus.stall      = bus.req_valid & ~req_ready;
    assign bus.resp_valid = resp.valid;
    assign bus.resp_rdata = resp.rdata;
    assign bus.resp_err   = resp.err;

endmodule
